// File: rtl/wb_omi_pkg.sv
// Shared Wishbone/OMI definitions for wb_omi_master and wb_omi_host.
// Holds the bus widths, the initiator FSM states and the timeout defaults.
package wb_omi_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    localparam int               TIMEOUT_DEF  = 1024;
    localparam logic [WB_DW-1:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } mst_state_e;

endpackage

// File: rtl/wb_omi_master_if.sv
// Command, response and Wishbone bundle of wb_omi_master.
// The master modport is the initiator's view; slave is the opposite side.
interface wb_omi_master_if;
    import wb_omi_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [WB_AW-1:0] cmd_adr;
    logic [WB_SW-1:0] cmd_sel;
    logic [WB_DW-1:0] cmd_dat;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WB_DW-1:0] rsp_dat;
    logic             rsp_err;
    logic             rsp_we;

    logic             wb_cyc;
    logic             wb_stb;
    logic [WB_AW-1:0] wb_adr;
    logic             wb_we;
    logic [WB_SW-1:0] wb_sel;
    logic [WB_DW-1:0] wb_dat_o;
    logic             wb_ack;
    logic [WB_DW-1:0] wb_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err, rsp_we,
        input  rsp_ready,
        output wb_cyc, wb_stb, wb_adr, wb_we, wb_sel, wb_dat_o,
        input  wb_ack, wb_dat_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err, rsp_we,
        output rsp_ready,
        input  wb_cyc, wb_stb, wb_adr, wb_we, wb_sel, wb_dat_o,
        output wb_ack, wb_dat_i
    );

endinterface

// File: rtl/wb_omi_master_timer.sv
// Bus timeout counter with terminal-count flag plus a saturating
// timeout event counter; used only with WB_OMI_MASTER_TIMEOUT_EN.
module wb_omi_master_timer
    import wb_omi_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic       err_inc,
    output logic       tc,
    output logic [7:0] err_cnt
);

    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign tc      = (cnt_q == 16'(TIMEOUT_CYC - 1));
    assign err_cnt = err_q;

endmodule

// File: rtl/wb_omi_master.sv
// Single-outstanding Wishbone classic initiator driven by a cmd/rsp stream.
// Define WB_OMI_MASTER_TIMEOUT_EN to add the bus timeout and error counter.
module wb_omi_master
    import wb_omi_pkg::*;
#(
    parameter int               TIMEOUT_CYC = TIMEOUT_DEF,
    parameter logic [WB_DW-1:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_omi_master_if.master bus,
    output logic [7:0] err_cnt
);

    mst_state_e state_q, state_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             cyc_q, cyc_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WB_AW-1:0] adr_q, adr_d;
    logic             we_q, we_d;
    logic [WB_SW-1:0] sel_q, sel_d;
    logic [WB_DW-1:0] dat_q, dat_d;
    logic [WB_DW-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;

    logic tmr_clr, tmr_inc, tmr_err, tmr_tc;

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        we_d      = we_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        tmr_err   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    adr_d   = bus.cmd_adr;
                    we_d    = bus.cmd_we;
                    sel_d   = bus.cmd_sel;
                    dat_d   = bus.cmd_dat;
                    tmr_clr = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ack has priority over a timeout in the same cycle
                if (bus.wb_ack) begin
                    rsp_dat_d = we_q ? '0 : bus.wb_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (tmr_tc) begin
                    rsp_dat_d = ERR_DATA;
                    rsp_err_d = 1'b1;
                    tmr_err   = 1'b1;
                    state_d   = RESP;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs are registered from the next state
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        cyc_d       = (state_d == BUS);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef WB_OMI_MASTER_TIMEOUT_EN
    wb_omi_master_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .err_inc (tmr_err),
        .tc      (tmr_tc),
        .err_cnt (err_cnt)
    );
`else
    logic unused_tmr;
    assign unused_tmr = ^{tmr_clr, tmr_inc, tmr_err, ERR_DATA, TIMEOUT_CYC};
    assign tmr_tc     = 1'b0;
    assign err_cnt    = '0;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_we    = we_q;
    assign bus.wb_cyc    = cyc_q;
    assign bus.wb_stb    = cyc_q;
    assign bus.wb_adr    = adr_q;
    assign bus.wb_we     = we_q;
    assign bus.wb_sel    = sel_q;
    assign bus.wb_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_omi_master.sv
// Directed bench for wb_omi_master: vector table plus hand-written
// sequences for late ack, backpressure and reset in BUS.
module tb_wb_omi_master;
    import wb_omi_pkg::*;

    localparam int TO = 8;
`ifdef WB_OMI_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    wb_omi_master_if bus ();

    wb_omi_master #(
        .TIMEOUT_CYC (TO),
        .ERR_DATA    (32'hFFFF_FFFF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          ack_after;
        logic [31:0] ack_dat;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
        int          bp;
        bit          late_ack;
    } vec_t;

    vec_t vecs[6];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_ec = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  k;
        int  cyc_n;
        int  lat;
        bit  done;
        bit  stable;
        bit  hold_ok;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = v.we;
        bus.cmd_adr   = v.adr;
        bus.cmd_sel   = v.sel;
        bus.cmd_dat   = v.dat;
        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d_accept", idx), 32'(k < 50), 32'd1);
        @(posedge clk);
        cyc_n  = 0;
        lat    = 0;
        done   = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.rsp_valid) begin
                done = 1'b1;
                lat  = i + 1;
            end else begin
                if (bus.wb_cyc) begin
                    cyc_n++;
                    if (bus.wb_stb !== 1'b1 || bus.wb_adr !== v.adr ||
                        bus.wb_we !== v.we || bus.wb_sel !== v.sel ||
                        bus.wb_dat_o !== v.dat)
                        stable = 1'b0;
                end
                bus.wb_ack   = (i == v.ack_after);
                bus.wb_dat_i = bus.wb_ack ? v.ack_dat : 32'h0;
            end
        end
        bus.wb_ack   = 1'b0;
        bus.wb_dat_i = 32'h0;
        if (v.exp_err && exp_ec < 255) exp_ec++;
        chk($sformatf("v%0d_rsp_seen", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_rsp_dat", idx), bus.rsp_dat, v.exp_dat);
        chk($sformatf("v%0d_rsp_err", idx), 32'(bus.rsp_err), 32'(v.exp_err));
        chk($sformatf("v%0d_rsp_we", idx), 32'(bus.rsp_we), 32'(v.we));
        chk($sformatf("v%0d_cyc_len", idx), 32'(cyc_n), 32'(v.exp_cyc));
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_cyc + 1));
        chk($sformatf("v%0d_wb_stable", idx), 32'(stable), 32'd1);
        chk($sformatf("v%0d_cyc_drop", idx), 32'(bus.wb_cyc), 32'd0);
        chk($sformatf("v%0d_err_cnt", idx), 32'(err_cnt), 32'(exp_ec));
        hold_ok = 1'b1;
        for (int i = 0; i < v.bp; i++) begin
            bus.wb_ack   = v.late_ack && (i == 0);
            bus.wb_dat_i = bus.wb_ack ? 32'h7777_7777 : 32'h0;
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== v.exp_dat ||
                bus.rsp_err !== v.exp_err || bus.cmd_ready !== 1'b0 ||
                bus.wb_cyc !== 1'b0 || err_cnt !== 8'(exp_ec))
                hold_ok = 1'b0;
        end
        bus.wb_ack   = 1'b0;
        bus.wb_dat_i = 32'h0;
        if (v.bp > 0)
            chk($sformatf("v%0d_rsp_hold", idx), 32'(hold_ok), 32'd1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk($sformatf("v%0d_ready_back", idx), 32'(bus.cmd_ready), 32'd1);
        chk($sformatf("v%0d_rsp_gone", idx), 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_sel   = '0;
        bus.cmd_dat   = '0;
        bus.rsp_ready = 1'b0;
        bus.wb_ack    = 1'b0;
        bus.wb_dat_i  = '0;

        vecs[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 32'h1234_5678,
                    32'h1234_5678, 1'b0, 1, 0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0020, 4'h3, 32'hCAFE_F00D, 5,
                    32'hDEAD_BEEF, 32'h0, 1'b0, 6, 0, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0030, 4'hF, 32'h0,
                    TO_EN ? -1 : 12, 32'h5555_AAAA,
                    TO_EN ? 32'hFFFF_FFFF : 32'h5555_AAAA,
                    TO_EN, TO_EN ? TO : 13, 3, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0034, 4'hF, 32'h0, TO - 1,
                    32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, TO, 0, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0003, 4'h1, 32'h0, 2, 32'hA5A5_0001,
                    32'hA5A5_0001, 1'b0, 3, 0, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFC, 4'hC, 32'h0123_4567, 0,
                    32'h8888_9999, 32'h0, 1'b0, 1, 4, 1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_wb_cyc", 32'(bus.wb_cyc), 32'd0);
        chk("rst_wb_adr", bus.wb_adr, 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // streaming source against response backpressure
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h0000_0040;
        bus.cmd_sel   = 4'hF;
        chk("bp_ready0", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_cyc1", 32'(bus.wb_cyc), 32'd1);
        bus.cmd_adr  = 32'h0000_0044;
        bus.wb_ack   = 1'b1;
        bus.wb_dat_i = 32'h1111_2222;
        @(negedge clk);
        bus.wb_ack   = 1'b0;
        bus.wb_dat_i = 32'h0;
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", i),
                {bus.rsp_dat[29:0], bus.cmd_ready, bus.wb_cyc},
                {30'(32'h1111_2222), 1'b0, 1'b0});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp_idle_cyc", 32'(bus.wb_cyc), 32'd0);
        chk("bp_idle_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("bp_next_cyc", 32'(bus.wb_cyc), 32'd1);
        chk("bp_next_adr", bus.wb_adr, 32'h0000_0044);
        bus.wb_ack   = 1'b1;
        bus.wb_dat_i = 32'h3333_4444;
        @(negedge clk);
        bus.wb_ack   = 1'b0;
        bus.wb_dat_i = 32'h0;
        chk("bp_next_dat", bus.rsp_dat, 32'h3333_4444);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // asynchronous reset in the middle of a bus cycle
        bus.cmd_valid = 1'b1;
        bus.cmd_adr   = 32'h0000_0050;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("rb_cyc_before", 32'(bus.wb_cyc), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rb_cyc_async", 32'(bus.wb_cyc), 32'd0);
        chk("rb_stb_async", 32'(bus.wb_stb), 32'd0);
        chk("rb_ready_low", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rb_ready_rel", 32'(bus.cmd_ready), 32'd1);
        chk("rb_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rb_err_cnt", 32'(err_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
